// File: rtl/tt_minterm_scanner_pkg.sv
// -----------------------------------------------------------------------------
// tt_scan_pkg
// Purpose : shared types and constants for the minterm scanner slice.
//           Holds the scanner state encoding, vector/index sizing, the
//           full-mask constant and a helper used by the minterm streamer.
// Ports   : none (package).
// -----------------------------------------------------------------------------
package tt_scan_pkg;

   localparam int N_VECTORS = 16;
   localparam int IDX_W     = 4;
   localparam logic [N_VECTORS-1:0] FULL_MASK = 16'hFFFF;
   localparam logic [IDX_W-1:0]     IDX_MAX   = 4'd15;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_DRIVE  = 3'd1,
      ST_SAMPLE = 3'd2,
      ST_STREAM = 3'd3,
      ST_DONE   = 3'd4
   } scan_state_t;

   // True when no bit of m above position p is set (p itself is ignored).
   function automatic logic no_higher_bit(input logic [N_VECTORS-1:0] m,
                                          input logic [IDX_W-1:0]     p);
      logic [N_VECTORS-1:0] sh;
      sh = m >> p;
      return ((sh & (FULL_MASK << 1)) == 16'h0000);
   endfunction

endpackage

// File: rtl/tt_minterm_scanner_if.sv
// -----------------------------------------------------------------------------
// tt_minterm_scanner_if
// Purpose : valid/ready minterm stream between the scanner and its consumer.
// Signals : m_valid  beat valid
//           m_ready  consumer ready
//           m_index  minterm index of the current beat
//           m_last   current beat is the highest set minterm
// Modports: master (scanner side), slave (consumer side).
// -----------------------------------------------------------------------------
interface tt_minterm_scanner_if;
   import tt_scan_pkg::*;

   logic             m_valid;
   logic             m_ready;
   logic [IDX_W-1:0] m_index;
   logic             m_last;

   modport master (output m_valid, output m_index, output m_last, input m_ready);
   modport slave  (input m_valid, input m_index, input m_last, output m_ready);

endinterface

// File: rtl/tt_minterm_scanner_streamer.sv
// -----------------------------------------------------------------------------
// tt_mask_streamer
// Purpose : walks a 16-bit truth-table mask from bit 0 upward and emits one
//           valid/ready beat per set bit. Clear bits are skipped one per cycle.
// Ports   : clk, rst_n   clock / async active-low reset
//           load         one-cycle pulse: capture load_mask and start at ptr 0
//           load_mask    mask to stream (already includes the final sample)
//           m            stream master modport
//           last_step    high in the cycle ptr 15 is consumed or skipped
// -----------------------------------------------------------------------------
module tt_mask_streamer
   import tt_scan_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 load,
   input  logic [N_VECTORS-1:0] load_mask,
   tt_minterm_scanner_if.master m,
   output logic                 last_step
);

   logic                 active_r;
   logic [IDX_W-1:0]     ptr_r;
   logic [N_VECTORS-1:0] mask_r;
   logic                 valid_r;
   logic [IDX_W-1:0]     index_r;
   logic                 last_r;
   logic                 advance_s;
   logic [IDX_W-1:0]     next_ptr_s;

   assign m.m_valid = valid_r;
   assign m.m_index = index_r;
   assign m.m_last  = last_r;

   // Pointer moves on a skip (no beat pending) or a completed beat.
   always_comb begin
      advance_s  = active_r & (~valid_r | m.m_ready);
      next_ptr_s = ptr_r + 4'd1;
      last_step  = advance_s & (ptr_r == IDX_MAX);
   end

   // Pointer walk with outputs registered for the position being presented.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_r <= 1'b0;
         ptr_r    <= 4'd0;
         mask_r   <= 16'h0000;
         valid_r  <= 1'b0;
         index_r  <= 4'd0;
         last_r   <= 1'b0;
      end else if (load) begin
         active_r <= 1'b1;
         ptr_r    <= 4'd0;
         mask_r   <= load_mask;
         valid_r  <= load_mask[0];
         index_r  <= 4'd0;
         last_r   <= load_mask[0] & no_higher_bit(load_mask, 4'd0);
      end else if (advance_s) begin
         if (ptr_r == IDX_MAX) begin
            active_r <= 1'b0;
            valid_r  <= 1'b0;
            last_r   <= 1'b0;
         end else begin
            ptr_r   <= next_ptr_s;
            valid_r <= mask_r[next_ptr_s];
            index_r <= next_ptr_s;
            last_r  <= mask_r[next_ptr_s] & no_higher_bit(mask_r, next_ptr_s);
         end
      end
   end

endmodule

// File: rtl/tt_minterm_scanner.sv
// -----------------------------------------------------------------------------
// tt_minterm_scanner
// Purpose : sweeps all 16 {x,y,w,z} vectors into an external 4-input function,
//           samples s after SETTLE_CYCLES, builds the truth-table mask and then
//           replays its minterm indices as a valid/ready stream.
// Params  : SETTLE_CYCLES (1..15) cycles each vector is held before sampling
//           CNT_W         settle counter width
// Ports   : clk, rst_n, start            control
//           probe_x/y/w/z, probe_s       function-under-test drive / return
//           busy, done, tt_mask, empty   status
//           m                            minterm stream (master)
//           minterm_count                popcount of tt_mask, only when
//                                        TT_SCAN_MINTERM_COUNT_EN is defined
// -----------------------------------------------------------------------------
module tt_minterm_scanner
   import tt_scan_pkg::*;
#(
   parameter int SETTLE_CYCLES = 1,
   parameter int CNT_W         = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   output logic                 probe_x,
   output logic                 probe_y,
   output logic                 probe_w,
   output logic                 probe_z,
   input  logic                 probe_s,
   output logic                 busy,
   output logic                 done,
   output logic [N_VECTORS-1:0] tt_mask,
   tt_minterm_scanner_if.master m,
`ifdef TT_SCAN_MINTERM_COUNT_EN
   output logic [4:0]           minterm_count,
`endif
   output logic                 empty
);

   scan_state_t          state_r;
   logic [IDX_W-1:0]     idx_r;
   logic [CNT_W-1:0]     settle_r;
   logic [IDX_W-1:0]     probe_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 empty_r;
   logic [N_VECTORS-1:0] mask_r;
   logic                 load_s;
   logic [N_VECTORS-1:0] load_mask_s;
   logic                 last_step_s;
`ifdef TT_SCAN_MINTERM_COUNT_EN
   logic [4:0]           count_r;
   assign minterm_count = count_r;
`endif

   assign {probe_x, probe_y, probe_w, probe_z} = probe_r;
   assign busy    = busy_r;
   assign done    = done_r;
   assign empty   = empty_r;
   assign tt_mask = mask_r;

   // Streamer is loaded on the final sample; bit 15 is forwarded from
   // probe_s so the first beat is valid in the first STREAM cycle.
   always_comb begin
      load_s      = 1'b0;
      load_mask_s = mask_r;
      if ((state_r == ST_SAMPLE) && (idx_r == IDX_MAX)) begin
         load_s                   = 1'b1;
         load_mask_s[N_VECTORS-1] = probe_s;
      end else begin
         load_s = 1'b0;
      end
   end

   tt_mask_streamer u_streamer (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_s),
      .load_mask (load_mask_s),
      .m         (m),
      .last_step (last_step_s)
   );

   // Scanner FSM: vector sweep, sampling, and hand-off to the streamer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= ST_IDLE;
         idx_r    <= 4'd0;
         settle_r <= '0;
         probe_r  <= 4'd0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         empty_r  <= 1'b0;
         mask_r   <= 16'h0000;
`ifdef TT_SCAN_MINTERM_COUNT_EN
         count_r  <= 5'd0;
`endif
      end else begin
         case (state_r)
            ST_IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  state_r  <= ST_DRIVE;
                  idx_r    <= 4'd0;
                  settle_r <= '0;
                  probe_r  <= 4'd0;
                  busy_r   <= 1'b1;
                  empty_r  <= 1'b0;
                  mask_r   <= 16'h0000;
`ifdef TT_SCAN_MINTERM_COUNT_EN
                  count_r  <= 5'd0;
`endif
               end
            end
            ST_DRIVE: begin
               if (settle_r == CNT_W'(SETTLE_CYCLES - 1)) begin
                  settle_r <= '0;
                  state_r  <= ST_SAMPLE;
               end else begin
                  settle_r <= settle_r + {{(CNT_W-1){1'b0}}, 1'b1};
               end
            end
            ST_SAMPLE: begin
               mask_r[idx_r] <= probe_s;
`ifdef TT_SCAN_MINTERM_COUNT_EN
               count_r <= count_r + {4'd0, probe_s};
`endif
               if (idx_r == IDX_MAX) begin
                  state_r <= ST_STREAM;
               end else begin
                  idx_r   <= idx_r + 4'd1;
                  probe_r <= idx_r + 4'd1;
                  state_r <= ST_DRIVE;
               end
            end
            ST_STREAM: begin
               if (last_step_s) begin
                  state_r <= ST_DONE;
                  done_r  <= 1'b1;
                  empty_r <= (mask_r == 16'h0000);
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
               done_r  <= 1'b0;
               busy_r  <= 1'b0;
               probe_r <= 4'd0;
            end
            default: begin
               state_r <= ST_IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
               probe_r <= 4'd0;
            end
         endcase
      end
   end

endmodule
